// File: rtl/mipi_tx_lane_seq.sv
// mipi_tx_lane_seq: multi-lane MIPI D-PHY HS transmit sequencer (byte clock domain).
// Walks LP-11 -> LP-01 -> LP-00 -> HS-0 -> SYNC -> DATA -> TRAIL -> LP-11 and
// presents one HS byte per lane each cycle to an external 8:1 serializer.
//
// Ports:
//   clk_hs     byte clock
//   reset      synchronous active-high reset
//   lane_en    per-lane enable, sampled on burst start (only with MIPI_TX_LANE_MASK_EN)
//   tx_req     level request for an HS burst
//   tx_valid   tx_data valid
//   tx_last    current beat is the last of the burst
//   tx_data    lane i byte at [8i+7:8i]
//   tx_ready   beat accepted when tx_valid & tx_ready (DATA only)
//   busy       sequencer not idle
//   underflow  sticky: tx_valid low while in DATA
//   hs_en      per-lane HS driver enable
//   hs_byte    per-lane HS byte
//   lp_p/lp_n  per-lane LP Dp/Dn levels
//
// Build option: define MIPI_TX_LANE_MASK_EN to add the lane_en input.
module mipi_tx_lane_seq #(
  parameter int unsigned NUM_LANES    = 2,
  parameter int unsigned T_LPX        = 2,
  parameter int unsigned T_HS_PREPARE = 3,
  parameter int unsigned T_HS_ZERO    = 4,
  parameter int unsigned T_HS_TRAIL   = 3,
  parameter int unsigned T_HS_EXIT    = 2
) (
  input  logic                   clk_hs,
  input  logic                   reset,
`ifdef MIPI_TX_LANE_MASK_EN
  input  logic [NUM_LANES-1:0]   lane_en,
`endif
  input  logic                   tx_req,
  input  logic                   tx_valid,
  input  logic                   tx_last,
  input  logic [8*NUM_LANES-1:0] tx_data,
  output logic                   tx_ready,
  output logic                   busy,
  output logic                   underflow,
  output logic [NUM_LANES-1:0]   hs_en,
  output logic [8*NUM_LANES-1:0] hs_byte,
  output logic [NUM_LANES-1:0]   lp_p,
  output logic [NUM_LANES-1:0]   lp_n
);

  localparam int unsigned T_M1  = (T_LPX > T_HS_PREPARE) ? T_LPX : T_HS_PREPARE;
  localparam int unsigned T_M2  = (T_M1 > T_HS_ZERO) ? T_M1 : T_HS_ZERO;
  localparam int unsigned T_M3  = (T_M2 > T_HS_TRAIL) ? T_M2 : T_HS_TRAIL;
  localparam int unsigned T_MAX = (T_M3 > T_HS_EXIT) ? T_M3 : T_HS_EXIT;
  localparam int unsigned CW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LPX, S_PREP, S_ZERO, S_SYNC, S_DATA, S_TRAIL, S_EXIT
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_LANES-1:0]   lp_p_q, lp_p_d, lp_n_q, lp_n_d, hs_en_q, hs_en_d;
  logic [8*NUM_LANES-1:0] hs_byte_q, hs_byte_d;
  logic                   tx_ready_q, tx_ready_d, busy_q, busy_d;
  logic                   underflow_q, underflow_d;
  logic [NUM_LANES-1:0]   last_b7_q, last_b7_d;
  logic [NUM_LANES-1:0]   lane_mask_d;
  logic                   req_ok;
  logic                   cnt_zero;
  logic                   accept;

  // Lane mask is captured while idle, so it freezes on the IDLE->LPX edge.
`ifdef MIPI_TX_LANE_MASK_EN
  logic [NUM_LANES-1:0] lane_mask_q;
  assign lane_mask_d = (state_q == S_IDLE) ? lane_en : lane_mask_q;
  assign req_ok      = tx_req && (lane_en != '0);

  always_ff @(posedge clk_hs) begin
    if (reset) lane_mask_q <= '1;
    else       lane_mask_q <= lane_mask_d;
  end
`else
  assign lane_mask_d = '1;
  assign req_ok      = tx_req;
`endif

  assign cnt_zero = (cnt_q == '0);
  assign accept   = (state_q == S_DATA) && tx_valid;

  // Next state, counter and registered-output values (outputs follow state_d).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    underflow_d = underflow_q;
    lp_p_d      = lp_p_q;
    lp_n_d      = lp_n_q;
    hs_en_d     = '0;
    hs_byte_d   = hs_byte_q;
    last_b7_d   = last_b7_q;

    case (state_q)
      S_IDLE: if (req_ok) begin state_d = S_LPX; cnt_d = CW'(T_LPX - 1); end
      S_LPX: begin
        if (cnt_zero) begin state_d = S_PREP; cnt_d = CW'(T_HS_PREPARE - 1); end
        else cnt_d = cnt_q - CW'(1);
      end
      S_PREP: begin
        if (cnt_zero) begin state_d = S_ZERO; cnt_d = CW'(T_HS_ZERO - 1); end
        else cnt_d = cnt_q - CW'(1);
      end
      S_ZERO: begin
        if (cnt_zero) begin state_d = S_SYNC; cnt_d = '0; end
        else cnt_d = cnt_q - CW'(1);
      end
      S_SYNC: state_d = S_DATA;
      S_DATA: begin
        if (!tx_valid) begin
          underflow_d = 1'b1;
          state_d     = S_TRAIL;
          cnt_d       = CW'(T_HS_TRAIL - 1);
        end else if (tx_last) begin
          // One extra TRAIL cycle carries the final byte out before the trail pattern.
          state_d = S_TRAIL;
          cnt_d   = CW'(T_HS_TRAIL);
        end
      end
      S_TRAIL: begin
        if (cnt_zero) begin state_d = S_EXIT; cnt_d = CW'(T_HS_EXIT - 1); end
        else cnt_d = cnt_q - CW'(1);
      end
      S_EXIT: begin
        if (cnt_zero) begin state_d = S_IDLE; cnt_d = '0; end
        else cnt_d = cnt_q - CW'(1);
      end
      default: begin state_d = S_IDLE; cnt_d = '0; end
    endcase

    tx_ready_d = (state_d == S_DATA);
    busy_d     = (state_d != S_IDLE);

    case (state_d)
      S_LPX:  begin lp_p_d = '0; lp_n_d = '1; hs_byte_d = '0; end
      S_PREP: begin lp_p_d = '0; lp_n_d = '0; hs_byte_d = '0; end
      S_ZERO: begin hs_en_d = '1; hs_byte_d = '0; end
      S_SYNC: begin hs_en_d = '1; hs_byte_d = {NUM_LANES{8'hB8}}; last_b7_d = '1; end
      S_DATA, S_TRAIL: begin
        hs_en_d = '1;
        if (accept) begin
          hs_byte_d = tx_data;
          for (int i = 0; i < NUM_LANES; i++) last_b7_d[i] = tx_data[8*i+7];
        end else if (state_d == S_TRAIL) begin
          for (int i = 0; i < NUM_LANES; i++) hs_byte_d[8*i +: 8] = {8{~last_b7_q[i]}};
        end
      end
      default: begin lp_p_d = '1; lp_n_d = '1; hs_byte_d = '0; end
    endcase

    // Disabled lanes stay parked in LP-11.
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!lane_mask_d[i]) begin
        lp_p_d[i]            = 1'b1;
        lp_n_d[i]            = 1'b1;
        hs_en_d[i]           = 1'b0;
        hs_byte_d[8*i +: 8]  = '0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_hs) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lp_p_q      <= '1;
      lp_n_q      <= '1;
      hs_en_q     <= '0;
      hs_byte_q   <= '0;
      tx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      underflow_q <= 1'b0;
      last_b7_q   <= '1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lp_p_q      <= lp_p_d;
      lp_n_q      <= lp_n_d;
      hs_en_q     <= hs_en_d;
      hs_byte_q   <= hs_byte_d;
      tx_ready_q  <= tx_ready_d;
      busy_q      <= busy_d;
      underflow_q <= underflow_d;
      last_b7_q   <= last_b7_d;
    end
  end

  assign tx_ready  = tx_ready_q;
  assign busy      = busy_q;
  assign underflow = underflow_q;
  assign hs_en     = hs_en_q;
  assign hs_byte   = hs_byte_q;
  assign lp_p      = lp_p_q;
  assign lp_n      = lp_n_q;

endmodule
